// File: rtl/next_pc_unit_pkg.sv
// Shared operation codes, FSM state encoding and small helpers
// for the execute-stage next-PC unit.
package next_pc_unit_pkg;

  typedef enum logic [1:0] {
    NPC_BOOT = 2'd0,
    NPC_RUN  = 2'd1,
    NPC_HOLD = 2'd2,
    NPC_TRAP = 2'd3
  } npc_state_t;

  localparam logic [6:0] ALU_ADD   = 7'h00;
  localparam logic [6:0] ALU_SUB   = 7'h01;
  localparam logic [6:0] ALU_AND   = 7'h02;
  localparam logic [6:0] ALU_OR    = 7'h03;
  localparam logic [6:0] ALU_XOR   = 7'h04;
  localparam logic [6:0] ALU_SLL   = 7'h05;
  localparam logic [6:0] ALU_SRL   = 7'h06;
  localparam logic [6:0] ALU_SRA   = 7'h07;
  localparam logic [6:0] ALU_SLT   = 7'h08;
  localparam logic [6:0] ALU_SLTU  = 7'h09;
  localparam logic [6:0] ALU_LUI   = 7'h0A;
  localparam logic [6:0] ALU_AUIPC = 7'h0B;
  localparam logic [6:0] ALU_JAL   = 7'h20;
  localparam logic [6:0] ALU_JALR  = 7'h21;
  localparam logic [6:0] ALU_BEQ   = 7'h28;
  localparam logic [6:0] ALU_BNE   = 7'h29;
  localparam logic [6:0] ALU_BLT   = 7'h2C;
  localparam logic [6:0] ALU_BGE   = 7'h2D;
  localparam logic [6:0] ALU_BLTU  = 7'h2E;
  localparam logic [6:0] ALU_BGEU  = 7'h2F;

  // A redirect target must be word aligned; anything else traps.
  function automatic logic is_misaligned(input logic [31:0] addr);
    return (addr[1:0] != 2'b00);
  endfunction

endpackage

// File: rtl/next_pc_unit_branch_cmp.sv
// Purely combinational branch/jump resolution: decides whether the
// execute-stage control instruction redirects the PC.
module branch_cmp
  import next_pc_unit_pkg::*;
(
  input  logic [6:0]  alu_code,
  input  logic [31:0] rs1,
  input  logic [31:0] rs2,
  output logic        taken
);

  logic eq;
  logic lt_signed;
  logic lt_unsigned;

  // Shared comparator results feeding the per-opcode decode.
  always_comb begin
    eq          = (rs1 == rs2);
    lt_signed   = ($signed(rs1) < $signed(rs2));
    lt_unsigned = (rs1 < rs2);
  end

  // Unknown codes fall through to not-taken so they advance sequentially.
  always_comb begin
    taken = 1'b0;
    case (alu_code)
      ALU_JAL:  taken = 1'b1;
      ALU_JALR: taken = 1'b1;
      ALU_BEQ:  taken = eq;
      ALU_BNE:  taken = !eq;
      ALU_BLT:  taken = lt_signed;
      ALU_BGE:  taken = !lt_signed;
      ALU_BLTU: taken = lt_unsigned;
      ALU_BGEU: taken = !lt_unsigned;
      default:  taken = 1'b0;
    endcase
  end

endmodule

// File: rtl/next_pc_unit.sv
// Execute-stage next-PC unit: target adder, redirect/trap FSM and the
// architectural PC register driving fetch.
module next_pc_unit
  import next_pc_unit_pkg::*;
#(
  parameter logic [31:0] RESET_VECTOR = 32'h0000_0000,
  parameter logic [31:0] TRAP_VECTOR  = 32'h0000_0010
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        ex_valid,
  input  logic        stall,
  input  logic [6:0]  alu_code,
  input  logic [31:0] npc_op1,
  input  logic [31:0] npc_op2,
  input  logic [31:0] rs1,
  input  logic [31:0] rs2,
  input  logic        trap_clear,
  output logic [31:0] pc,
  output logic        pc_valid,
  output logic        flush,
  output logic        trap,
  output logic [31:0] trap_epc
);

  npc_state_t  state;
  logic        taken;
  logic [31:0] target;
  logic [31:0] seq;

  branch_cmp u_branch_cmp (
    .alu_code (alu_code),
    .rs1      (rs1),
    .rs2      (rs2),
    .taken    (taken)
  );

  // Target and sequential addresses wrap modulo 2^32; JALR clears bit 0.
  always_comb begin
    target = npc_op1 + npc_op2;
    if (alu_code == ALU_JALR) begin
      target[0] = 1'b0;
    end else begin
      target[0] = target[0];
    end
    seq = pc + 32'd4;
  end

  // Control FSM with registered fetch-side outputs; flush is a single-cycle pulse.
  always_ff @(posedge clk) begin
    if (rst) begin
      state    <= NPC_BOOT;
      pc       <= RESET_VECTOR;
      pc_valid <= 1'b0;
      flush    <= 1'b0;
      trap     <= 1'b0;
      trap_epc <= 32'h0000_0000;
    end else begin
      flush <= 1'b0;
      case (state)
        NPC_BOOT: begin
          state    <= NPC_RUN;
          pc_valid <= 1'b1;
        end
        NPC_RUN: begin
          if (stall) begin
            state <= NPC_HOLD;
          end else if (ex_valid && taken) begin
            flush <= 1'b1;
            if (is_misaligned(target)) begin
              state    <= NPC_TRAP;
              pc       <= TRAP_VECTOR;
              trap_epc <= pc;
              trap     <= 1'b1;
            end else begin
              pc <= target;
            end
          end else if (ex_valid) begin
            pc <= seq;
          end else begin
            pc <= pc;
          end
        end
        NPC_HOLD: begin
          if (!stall) begin
            state <= NPC_RUN;
          end else begin
            state <= NPC_HOLD;
          end
        end
        NPC_TRAP: begin
          // Clearing during a stall parks in HOLD rather than resuming directly.
          if (trap_clear) begin
            trap  <= 1'b0;
            state <= stall ? NPC_HOLD : NPC_RUN;
          end else begin
            state <= NPC_TRAP;
          end
        end
        default: begin
          state    <= NPC_BOOT;
          pc       <= RESET_VECTOR;
          pc_valid <= 1'b0;
          trap     <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_next_pc_unit.sv
// Self-checking bench for next_pc_unit: directed scenarios followed by
// randomized traffic, all checked against a behavioural reference model.
module tb_next_pc_unit;
  import next_pc_unit_pkg::*;

  logic        clk = 1'b0;
  logic        rst, ex_valid, stall, trap_clear;
  logic [6:0]  alu_code;
  logic [31:0] npc_op1, npc_op2, rs1, rs2;
  logic [31:0] pc, trap_epc;
  logic        pc_valid, flush, trap;

  int checks = 0;
  int passed = 0;

  // Reference model state: mode 0=boot 1=run 2=hold 3=trap.
  int          m_mode;
  logic [31:0] m_pc, m_epc;
  logic        m_valid, m_flush, m_trap;

  always #5 clk = ~clk;

  next_pc_unit #(
    .RESET_VECTOR (32'h0000_0000),
    .TRAP_VECTOR  (32'h0000_0010)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .ex_valid   (ex_valid),
    .stall      (stall),
    .alu_code   (alu_code),
    .npc_op1    (npc_op1),
    .npc_op2    (npc_op2),
    .rs1        (rs1),
    .rs2        (rs2),
    .trap_clear (trap_clear),
    .pc         (pc),
    .pc_valid   (pc_valid),
    .flush      (flush),
    .trap       (trap),
    .trap_epc   (trap_epc)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs === exp) passed++;
    else $display("FAIL %s: got %h, expected %h (t=%0t)", tag, obs, exp, $time);
  endtask

  function automatic bit ref_taken(input logic [6:0] code, input logic [31:0] a, input logic [31:0] b);
    longint sa, sb;
    sa = longint'($signed(a));
    sb = longint'($signed(b));
    case (code)
      ALU_JAL, ALU_JALR: return 1'b1;
      ALU_BEQ:  return a == b;
      ALU_BNE:  return a != b;
      ALU_BLT:  return sa < sb;
      ALU_BGE:  return sa >= sb;
      ALU_BLTU: return a < b;
      ALU_BGEU: return a >= b;
      default:  return 1'b0;
    endcase
  endfunction

  task automatic model_step();
    longint unsigned sum;
    logic [31:0] tgt;
    sum = longint'(npc_op1) + longint'(npc_op2);
    tgt = 32'(sum % 64'h1_0000_0000);
    if (alu_code == ALU_JALR) tgt = tgt - (tgt % 32'd2);
    m_flush = 1'b0;
    if (rst) begin
      m_mode = 0; m_pc = 32'h0; m_valid = 1'b0; m_trap = 1'b0; m_epc = 32'h0;
    end else if (m_mode == 0) begin
      m_mode = 1; m_valid = 1'b1;
    end else if (m_mode == 1) begin
      if (stall) m_mode = 2;
      else if (ex_valid && ref_taken(alu_code, rs1, rs2)) begin
        m_flush = 1'b1;
        if (tgt % 32'd4 != 32'd0) begin
          m_epc = m_pc; m_pc = 32'h10; m_trap = 1'b1; m_mode = 3;
        end else m_pc = tgt;
      end else if (ex_valid) m_pc = 32'((longint'(m_pc) + 4) % 64'h1_0000_0000);
    end else if (m_mode == 2) begin
      if (!stall) m_mode = 1;
    end else begin
      if (trap_clear) begin
        m_trap = 1'b0; m_mode = stall ? 2 : 1;
      end
    end
  endtask

  task automatic step();
    @(posedge clk);
    model_step();
    #1;
    check("pc", pc, m_pc);
    check("pc_valid", pc_valid, m_valid);
    check("flush", flush, m_flush);
    check("trap", trap, m_trap);
    check("trap_epc", trap_epc, m_epc);
  endtask

  task automatic drive(input logic v, input logic st, input logic [6:0] code,
                       input logic [31:0] op1, input logic [31:0] op2,
                       input logic [31:0] a, input logic [31:0] b, input logic tc);
    ex_valid = v; stall = st; alu_code = code; npc_op1 = op1; npc_op2 = op2;
    rs1 = a; rs2 = b; trap_clear = tc;
    step();
  endtask

  task automatic idle();
    drive(1'b0, 1'b0, ALU_ADD, 32'h0, 32'h4, 32'h0, 32'h0, 1'b0);
  endtask

  logic [6:0] codes [0:21];

  initial begin
    codes = '{ALU_ADD, ALU_SUB, ALU_AND, ALU_OR, ALU_XOR, ALU_SLL, ALU_SRL, ALU_SRA,
              ALU_SLT, ALU_SLTU, ALU_LUI, ALU_AUIPC, ALU_JAL, ALU_JALR, ALU_BEQ,
              ALU_BNE, ALU_BLT, ALU_BGE, ALU_BLTU, ALU_BGEU, 7'h7F, 7'h55};
    m_mode = 0; m_pc = 32'h0; m_epc = 32'h0; m_valid = 1'b0; m_flush = 1'b0; m_trap = 1'b0;

    // Reset, then BOOT for one cycle with pc_valid low.
    rst = 1'b1;
    idle(); idle();
    check("reset_pc", pc, 32'h0);
    check("reset_valid", pc_valid, 32'h0);
    rst = 1'b0;
    idle();
    check("boot_valid", pc_valid, 32'h1);

    // Sequential and branch behaviour.
    drive(1'b1, 1'b0, ALU_JAL, 32'h0, 32'h100, 32'h0, 32'h0, 1'b0);
    check("jal_100", pc, 32'h100);
    drive(1'b1, 1'b0, ALU_ADD, 32'h100, 32'h4, 32'h0, 32'h0, 1'b0);
    check("add_seq", pc, 32'h104);
    check("add_noflush", flush, 32'h0);
    drive(1'b1, 1'b0, ALU_JAL, 32'h0, 32'h200, 32'h0, 32'h0, 1'b0);
    drive(1'b1, 1'b0, ALU_BEQ, 32'h200, 32'hFFFF_FFF0, 32'd5, 32'd5, 1'b0);
    check("beq_taken", pc, 32'h1F0);
    check("beq_flush", flush, 32'h1);
    idle();
    check("flush_pulse", flush, 32'h0);
    drive(1'b1, 1'b0, ALU_JAL, 32'h0, 32'h200, 32'h0, 32'h0, 1'b0);
    drive(1'b1, 1'b0, ALU_BEQ, 32'h200, 32'hFFFF_FFF0, 32'd5, 32'd6, 1'b0);
    check("beq_not_taken", pc, 32'h204);
    drive(1'b1, 1'b0, ALU_BLT, 32'h400, 32'h0, 32'hFFFF_FFFF, 32'd1, 1'b0);
    check("blt_signed", pc, 32'h400);
    drive(1'b1, 1'b0, ALU_BLTU, 32'h800, 32'h0, 32'hFFFF_FFFF, 32'd1, 1'b0);
    check("bltu_unsigned", pc, 32'h404);

    // JALR clears bit 0; misaligned JAL traps.
    drive(1'b1, 1'b0, ALU_JALR, 32'h301, 32'h0, 32'h0, 32'h0, 1'b0);
    check("jalr_bit0", pc, 32'h300);
    drive(1'b1, 1'b0, ALU_JAL, 32'h300, 32'h2, 32'h0, 32'h0, 1'b0);
    check("trap_pc", pc, 32'h10);
    check("trap_epc", trap_epc, 32'h300);
    check("trap_flag", trap, 32'h1);
    drive(1'b1, 1'b0, ALU_JAL, 32'h0, 32'h600, 32'h0, 32'h0, 1'b0);
    check("trap_ignores_ex", pc, 32'h10);
    drive(1'b0, 1'b0, ALU_ADD, 32'h0, 32'h4, 32'h0, 32'h0, 1'b1);
    check("trap_cleared", trap, 32'h0);

    // Stall freezes a taken JAL; it redirects once evaluated in RUN.
    for (int i = 0; i < 3; i++) drive(1'b1, 1'b1, ALU_JAL, 32'h0, 32'h500, 32'h0, 32'h0, 1'b0);
    check("stall_frozen", pc, 32'h10);
    drive(1'b1, 1'b0, ALU_JAL, 32'h0, 32'h500, 32'h0, 32'h0, 1'b0);
    check("hold_release", pc, 32'h10);
    drive(1'b1, 1'b0, ALU_JAL, 32'h0, 32'h500, 32'h0, 32'h0, 1'b0);
    check("stall_redirect", pc, 32'h500);

    // Reset while in HOLD.
    drive(1'b1, 1'b1, ALU_JAL, 32'h0, 32'h700, 32'h0, 32'h0, 1'b0);
    rst = 1'b1;
    drive(1'b1, 1'b1, ALU_JAL, 32'h0, 32'h700, 32'h0, 32'h0, 1'b0);
    check("rst_in_hold_pc", pc, 32'h0);
    check("rst_in_hold_valid", pc_valid, 32'h0);
    rst = 1'b0;
    idle();

    // Wrap-around of both adders, then trap_clear together with stall.
    drive(1'b1, 1'b0, ALU_JAL, 32'hFFFF_FFF0, 32'hC, 32'h0, 32'h0, 1'b0);
    drive(1'b1, 1'b0, ALU_ADD, 32'h0, 32'h4, 32'h0, 32'h0, 1'b0);
    check("seq_wrap", pc, 32'h0);
    drive(1'b1, 1'b0, ALU_JAL, 32'hFFFF_FFFC, 32'h8, 32'h0, 32'h0, 1'b0);
    check("target_wrap", pc, 32'h4);
    drive(1'b1, 1'b0, ALU_BNE, 32'h41, 32'h0, 32'd1, 32'd2, 1'b0);
    check("branch_trap", trap, 32'h1);
    drive(1'b0, 1'b1, ALU_ADD, 32'h0, 32'h4, 32'h0, 32'h0, 1'b1);
    check("clear_stall_trap", trap, 32'h0);
    drive(1'b1, 1'b1, ALU_ADD, 32'h0, 32'h4, 32'h0, 32'h0, 1'b0);
    check("clear_stall_hold", pc, 32'h10);
    idle();
    drive(1'b1, 1'b0, ALU_ADD, 32'h0, 32'h4, 32'h0, 32'h0, 1'b0);
    check("resume_seq", pc, 32'h14);

    // Randomized traffic against the model.
    for (int i = 0; i < 3000; i++) begin
      logic [31:0] a, op1, op2;
      rst = ($urandom_range(0, 99) == 0);
      a   = $urandom;
      op1 = $urandom;
      op2 = $urandom;
      if ($urandom_range(0, 7) != 0) begin
        op1 = op1 & 32'hFFFF_FFFC;
        op2 = op2 & 32'hFFFF_FFFC;
      end
      drive(($urandom_range(0, 3) != 0), ($urandom_range(0, 5) == 0),
            codes[$urandom_range(0, 21)], op1, op2, a,
            ($urandom_range(0, 2) == 0) ? a : 32'($urandom),
            ($urandom_range(0, 3) == 0));
    end

    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end

endmodule
